dma_transfer_controller: RTL and testbench
==========================================

// Module: dma_transfer_controller
// PURPOSE
//  Sequences one DMA block transfer from the external device into data memory.
//  Sits between the CPU-side interrupt/bus logic (command in, BR/BG handshake) and the d_mem write port.
//  On a start command it requests the bus and, once granted, writes BURSTS lines of LINE_WORDS words each.
//  It then releases the bus and raises the end interrupt.
// PARAMETERS
//  WORD_SIZE   16  bits per word
//  LINE_WORDS  4   words per memory line, i.e. per burst (mem_data width = LINE_WORDS*WORD_SIZE)
//  BURSTS      3   lines per transfer (default transfer = 12 words)
//  ADDR_W      16  address width
// PORTS
//  clk          in   1                    system clock, rising edge
//  reset_n      in   1                    asynchronous active-low reset
//  cmd          in   1                    start command, level; sampled only in IDLE
//  cmd_addr     in   ADDR_W               destination base address, captured with cmd
//  BG           in   1                    bus grant from the bus owner; may drop asynchronously when BR falls
//  BR           out  1                    bus request
//  ext_idx      out  $clog2(BURSTS)+1     index of the line the device must present on ext_data
//  ext_data     in   LINE_WORDS*WORD_SIZE line data from the device, valid while ext_idx is stable
//  mem_write    out  1                    d_mem write strobe, held until mem_done
//  mem_addr     out  ADDR_W               line-aligned write address
//  mem_data     out  LINE_WORDS*WORD_SIZE write data
//  mem_done     in   1                    d_mem write completion, one-cycle pulse
//  dma_end_int  out  1                    transfer-complete interrupt, one-cycle pulse
//  busy         out  1                    high in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; burst counter 0; base address register 0.
//  FSM states: IDLE -> REQ -> XFER -> WAIT -> (XFER | GAP | DONE) -> IDLE.
//  IDLE:
//   - On cmd=1: latch cmd_addr into base, clear cnt, assert BR, enter REQ.
//   - busy rises on the same edge.
//  REQ:
//   - Hold BR.
//   - On the first edge where BG=1, enter XFER.
//   - No timeout; wait indefinitely.
//  XFER (one cycle):
//   - Register mem_data <= ext_data and mem_addr <= base + cnt*LINE_WORDS.
//   - Assert mem_write and enter WAIT.
//   - ext_idx = cnt throughout.
//  WAIT:
//   - Hold mem_write, mem_addr and mem_data stable.
//   - On mem_done, on the same edge: drop mem_write and increment cnt.
//   - If cnt (pre-increment) == BURSTS-1, enter DONE; else enter XFER (or GAP, see CONFIGURATION).
//  DONE (one cycle):
//   - Deassert BR, pulse dma_end_int=1 for exactly this cycle, enter IDLE.
//   - busy falls when IDLE is entered.
//  Minimum transfer latency with 1-cycle memory: cmd to BR = 1 cycle; BG to dma_end_int = 2*BURSTS+1 cycles.
//  Address arithmetic:
//   - Modulo 2^ADDR_W; wrap-around is silent.
//   - The low log2(LINE_WORDS) bits of base are used as given (no forced alignment).
//  Bus rules:
//   - mem_write is asserted only in XFER/WAIT, and only while BG=1 was observed at entry to XFER.
//   - BG is never sampled after BR falls.
//  A mem_done outside WAIT is ignored.
//  cmd while busy is ignored (not queued); cmd held high after DONE starts a new transfer from IDLE.
//  BG deasserting mid-WAIT is a protocol error: the write is still held until mem_done.
//  Reset mid-transfer: everything returns to reset values immediately; BR and mem_write drop asynchronously.
// CONFIGURATION
//  DMA_CYCLE_STEAL_EN
//   - Defined: after each non-final burst, WAIT -> GAP instead of XFER. GAP drops BR for one cycle, then re-asserts
//     it and goes to REQ, releasing the bus to the CPU between lines. dma_end_int is unchanged.
//   - Undefined: GAP is absent and BR stays high for the whole transfer (burst mode).
// TESTING
//  1. Reset with cmd=1 held -> BR=0, mem_write=0, busy=0 until reset_n rises; BR=1 one cycle after reset_n rises.
//  2. cmd_addr=0x01F4, BG 2 cycles after BR, mem_done 1 cycle after each write ->
//     writes to 0x01F4/0x01F8/0x01FC in order, data = ext_data for ext_idx 0/1/2, one dma_end_int pulse, BR low after.
//  3. mem_done delayed 5 cycles on burst 1 -> mem_addr/mem_data stable for all 5 cycles; no extra write; total 3 writes.
//  4. cmd_addr=0xFFFC -> addresses 0xFFFC, 0x0000, 0x0004.
//  5. cmd re-pulsed during burst 1 -> ignored; exactly 3 writes, 1 interrupt. reset_n low during WAIT -> BR, mem_write and busy drop at once.
//  6. With DMA_CYCLE_STEAL_EN -> BR low for exactly 1 cycle after each of bursts 0 and 1; no write until BG seen again.
//     Without it -> BR continuously high from REQ to DONE.

Source files
------------

// File: rtl/dma_transfer_controller_if.sv
// Bus bundle for dma_transfer_controller: command, BR/BG handshake, device line
// fetch and d_mem write port. The master modport is the DMA side; the slave side
// is the CPU, bus owner, device and memory.
interface dma_transfer_controller_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BURSTS     = 3,
  parameter int unsigned ADDR_W     = 16
);
  localparam int unsigned LINE_W = LINE_WORDS * WORD_SIZE;
  localparam int unsigned IDX_W  = $clog2(BURSTS) + 1;

  logic              cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic              BG;
  logic              BR;
  logic [IDX_W-1:0]  ext_idx;
  logic [LINE_W-1:0] ext_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data;
  logic              mem_done;
  logic              dma_end_int;
  logic              busy;

  modport master (
    input  cmd, cmd_addr, BG, ext_data, mem_done,
    output BR, ext_idx, mem_write, mem_addr, mem_data, dma_end_int, busy
  );

  modport slave (
    output cmd, cmd_addr, BG, ext_data, mem_done,
    input  BR, ext_idx, mem_write, mem_addr, mem_data, dma_end_int, busy
  );
endinterface

// File: rtl/dma_transfer_controller.sv
// DMA block-transfer sequencer: on a start command it requests the bus, then
// copies BURSTS device lines into d_mem at consecutive line addresses from the
// captured base, releases the bus and pulses the end interrupt.
// Optional feature macro: DMA_CYCLE_STEAL_EN -- when defined, BR is dropped for
// one cycle between lines (GAP state) so the CPU can take the bus; otherwise BR
// stays high for the whole transfer.
module dma_transfer_controller #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BURSTS     = 3,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dma_transfer_controller_if.master   bus
);
  localparam int unsigned LINE_W = LINE_WORDS * WORD_SIZE;
  localparam int unsigned CNT_W  = $clog2(BURSTS) + 1;

`ifdef DMA_CYCLE_STEAL_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd5
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              br_q, br_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] line_addr_c;
  logic              last_c;

  // Destination of the current line; wraps silently modulo 2^ADDR_W.
  always_comb begin
    line_addr_c = base_q + ADDR_W'(ADDR_W'(cnt_q) * ADDR_W'(LINE_WORDS));
    last_c      = (cnt_q == CNT_W'(BURSTS - 1));
  end

  // State and all registered outputs; reset drops BR and mem_write at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      end_q       <= end_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output decode; end interrupt is high only in DONE.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    end_d       = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd) begin
          base_d  = bus.cmd_addr;
          cnt_d   = '0;
          br_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.BG) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        mem_data_d  = bus.ext_data;
        mem_addr_d  = line_addr_c;
        mem_write_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_done) begin
          mem_write_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          if (last_c) begin
            end_d   = 1'b1;
            state_d = S_DONE;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            br_d    = 1'b0;
            state_d = S_GAP;
`else
            state_d = S_XFER;
`endif
          end
        end
      end
`ifdef DMA_CYCLE_STEAL_EN
      S_GAP: begin
        br_d    = 1'b1;
        state_d = S_REQ;
      end
`endif
      S_DONE: begin
        br_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.BR          = br_q;
  assign bus.ext_idx     = cnt_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.dma_end_int = end_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_dma_transfer_controller.sv
// Directed bench for dma_transfer_controller: bus-owner and memory responders,
// a write/interrupt monitor, and one task per scenario.
module tb_dma_transfer_controller;
  localparam int unsigned LINE_W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dma_transfer_controller_if bus ();

  dma_transfer_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Device line contents: word w of line i is 0xA000 + 16*i + w.
  function automatic logic [LINE_W-1:0] line_data(input logic [2:0] idx);
    logic [15:0] b;
    b = 16'hA000 + {9'd0, idx, 4'd0};
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  assign bus.ext_data = line_data(bus.ext_idx);

  // Responder knobs
  int bg_delay  = 2;
  int slow_idx  = -1;
  int slow_lat  = 5;
  int bg_cnt    = 0;
  int wcnt      = 0;

  // Bus owner: grants bg_delay cycles after BR, withdraws as soon as BR falls.
  initial bus.BG = 1'b0;
  always @(posedge clk) begin
    #2;
    if (!bus.BR) begin
      bus.BG = 1'b0;
      bg_cnt = 0;
    end else if (!bus.BG) begin
      if (bg_cnt >= bg_delay) bus.BG = 1'b1;
      else bg_cnt++;
    end
  end

  // Memory: completes a write after a per-line latency with a one-cycle pulse.
  initial bus.mem_done = 1'b0;
  always @(posedge clk) begin
    #2;
    if (bus.mem_done) begin
      bus.mem_done = 1'b0;
      wcnt = 0;
    end else if (bus.mem_write) begin
      if (wcnt >= ((int'(bus.ext_idx) == slow_idx) ? slow_lat : 0)) bus.mem_done = 1'b1;
      else wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Monitor state
  logic [15:0]       wr_addr[$];
  logic [LINE_W-1:0] wr_data[$];
  int   end_cnt = 0, stab_err = 0, wr_no_bg = 0, mw_cyc = 0;
  int   br_low_cyc = 0, br_low_runs = 0;
  int   cyc = 0, bg_rise_cyc = -1, end_cyc = -1;
  logic prev_mw = 1'b0, prev_br = 1'b0, prev_bg = 1'b0;
  logic [15:0]       held_a;
  logic [LINE_W-1:0] held_d;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_write && !prev_mw) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
      held_a = bus.mem_addr;
      held_d = bus.mem_data;
      if (!bus.BG) wr_no_bg++;
    end else if (bus.mem_write && prev_mw) begin
      if (bus.mem_addr !== held_a || bus.mem_data !== held_d) stab_err++;
    end
    if (bus.mem_write) mw_cyc++;
    if (bus.dma_end_int) begin
      end_cnt++;
      end_cyc = cyc;
    end
    if (bus.BG && !prev_bg && bg_rise_cyc < 0) bg_rise_cyc = cyc;
    if (bus.busy && !bus.BR) begin
      br_low_cyc++;
      if (prev_br) br_low_runs++;
    end
    prev_mw = bus.mem_write;
    prev_br = bus.BR;
    prev_bg = bus.BG;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    end_cnt = 0; stab_err = 0; wr_no_bg = 0; mw_cyc = 0;
    br_low_cyc = 0; br_low_runs = 0; bg_rise_cyc = -1; end_cyc = -1;
  endtask

  task automatic start(input logic [15:0] addr);
    @(negedge clk);
    bus.cmd = 1'b1;
    bus.cmd_addr = addr;
    @(negedge clk);
    bus.cmd = 1'b0;
  endtask

  task automatic wait_end(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (end_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (end_cnt < target) begin
      errors++;
      $display("FAIL %s timeout: end_int count %0d, required %0d", name, end_cnt, target);
    end
  endtask

  task automatic test_reset();
    bus.cmd = 1'b1;
    bus.cmd_addr = 16'h0100;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.BR !== 1'b0 || bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.dma_end_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: BR=%b mw=%b busy=%b end=%b, required all 0",
                 bus.BR, bus.mem_write, bus.busy, bus.dma_end_int);
      end
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.BR !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_br: BR=%b, required 0", bus.BR);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.BR !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_cmd: BR=%b busy=%b, required 1 1", bus.BR, bus.busy);
    end
    bus.cmd = 1'b0;
    wait_end(1, 300, "reset_xfer");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0]       exp_a[3];
    logic [LINE_W-1:0] exp_d[3];
    exp_a = '{16'h01F4, 16'h01F8, 16'h01FC};
    exp_d = '{64'hA003_A002_A001_A000, 64'hA013_A012_A011_A010, 64'hA023_A022_A021_A020};
    clear_log();
    bg_delay = 2;
    start(16'h01F4);
    wait_end(1, 300, "basic");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() != 3) begin
      errors++;
      $display("FAIL basic_count: writes %0d, required 3", wr_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin
        errors++;
        $display("FAIL basic_write%0d: missing, required addr %h", i, exp_a[i]);
      end else if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_write%0d: addr %h data %h, required %h %h",
                 i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (end_cnt != 1 || bus.BR !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: ints %0d BR=%b busy=%b, required 1 0 0", end_cnt, bus.BR, bus.busy);
    end
`ifndef DMA_CYCLE_STEAL_EN
    checks++;
    if (end_cyc - bg_rise_cyc != 7) begin
      errors++;
      $display("FAIL basic_latency: BG to end_int %0d cycles, required 7", end_cyc - bg_rise_cyc);
    end
`endif
  endtask

  task automatic test_slow_mem();
    clear_log();
    slow_idx = 1;
    slow_lat = 5;
    start(16'h0400);
    wait_end(1, 300, "slow_mem");
    repeat (3) @(negedge clk);
    #1;
    slow_idx = -1;
    checks++;
    if (wr_addr.size() != 3 || stab_err != 0) begin
      errors++;
      $display("FAIL slow_mem_writes: writes %0d unstable %0d, required 3 0", wr_addr.size(), stab_err);
    end
    checks++;
    if (mw_cyc != 8) begin
      errors++;
      $display("FAIL slow_mem_hold: mem_write cycles %0d, required 8", mw_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a[3];
    exp_a = '{16'hFFFC, 16'h0000, 16'h0004};
    clear_log();
    start(16'hFFFC);
    wait_end(1, 300, "wrap");
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin
        errors++;
        $display("FAIL wrap_addr%0d: missing, required %h", i, exp_a[i]);
      end else if (wr_addr[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d: %h, required %h", i, wr_addr[i], exp_a[i]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd_busy();
    logic [15:0] exp_a[3];
    int n;
    exp_a = '{16'h0200, 16'h0204, 16'h0208};
    clear_log();
    start(16'h0200);
    n = 0;
    while (!(bus.mem_write && bus.ext_idx == 3'd1) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL cmd_busy_reach: burst 1 write not seen, required within 200 cycles");
    end
    bus.cmd = 1'b1;
    bus.cmd_addr = 16'h0F00;
    @(negedge clk);
    bus.cmd = 1'b0;
    wait_end(1, 300, "cmd_busy");
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() != 3 || end_cnt != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL cmd_busy_count: writes %0d ints %0d busy=%b, required 3 1 0",
               wr_addr.size(), end_cnt, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wr_addr.size() || wr_addr[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL cmd_busy_addr%0d: %h, required %h", i,
                 (i < wr_addr.size()) ? wr_addr[i] : 16'hxxxx, exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_log();
    slow_idx = 0;
    slow_lat = 5;
    start(16'h0300);
    n = 0;
    while (!bus.mem_write && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL reset_mid_reach: no write seen, required within 200 cycles");
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.BR !== 1'b0 || bus.mem_write !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: BR=%b mw=%b busy=%b, required 0 0 0",
               bus.BR, bus.mem_write, bus.busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    slow_idx = -1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || end_cnt != 0 || bus.ext_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b ints %0d idx %0d, required 0 0 0",
               bus.busy, end_cnt, bus.ext_idx);
    end
  endtask

  task automatic test_bus_release();
    clear_log();
    bg_delay = 1;
    start(16'h0500);
    wait_end(1, 300, "bus_release");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_addr.size() != 3 || wr_no_bg != 0) begin
      errors++;
      $display("FAIL bus_release_writes: writes %0d without_bg %0d, required 3 0", wr_addr.size(), wr_no_bg);
    end
`ifdef DMA_CYCLE_STEAL_EN
    checks++;
    if (br_low_cyc != 2 || br_low_runs != 2) begin
      errors++;
      $display("FAIL bus_release_gap: BR low cycles %0d runs %0d, required 2 2", br_low_cyc, br_low_runs);
    end
`else
    checks++;
    if (br_low_cyc != 0) begin
      errors++;
      $display("FAIL bus_release_burst: BR low cycles while busy %0d, required 0", br_low_cyc);
    end
`endif
    bg_delay = 2;
  endtask

  task automatic test_back_to_back();
    clear_log();
    @(negedge clk);
    bus.cmd_addr = 16'h0600;
    bus.cmd = 1'b1;
    wait_end(2, 600, "back_to_back");
    bus.cmd = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (end_cnt != 2 || wr_addr.size() != 6 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: ints %0d writes %0d busy=%b, required 2 6 0",
               end_cnt, wr_addr.size(), bus.busy);
    end
  endtask

  initial begin
    bus.cmd = 1'b0;
    bus.cmd_addr = 16'h0000;
    test_reset();
    test_basic();
    test_slow_mem();
    test_wrap();
    test_cmd_busy();
    test_reset_mid();
    test_bus_release();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
